// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci LFSR with parallel and serial seed load, run/hold control,
// period tracking and all-zero lock-up detection.
// Optional feature macro: LFSR_LOCKUP_RECOVER_EN. When it is defined, a run step taken from
// the all-zero state reloads DEFAULT_SEED.
module lfsr_gen #(
    parameter int unsigned      WIDTH        = 6,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(6'b110000),
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic [WIDTH-1:0] seed,
    input  logic             seed_shift_en,
    input  logic             seed_bit,
    input  logic             run_en,
    output logic [WIDTH-1:0] q,
    output logic             out_bit,
    output logic [WIDTH-1:0] step_cnt,
    output logic             period_done,
    output logic             lockup
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             pd_q, pd_d;
    logic             fb;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] q_shift;

    // Next-state selection: load > serial shift > run > hold.
    always_comb begin
        fb      = ^(q_q & TAPS);
        q_step  = {q_q[WIDTH-2:0], fb};
        q_shift = {q_q[WIDTH-2:0], seed_bit};
        q_d     = q_q;
        start_d = start_q;
        cnt_d   = cnt_q;
        pd_d    = 1'b0;
        if (load_en) begin
            q_d     = seed;
            start_d = seed;
            cnt_d   = '0;
        end else if (seed_shift_en) begin
            q_d     = q_shift;
            start_d = q_shift;
            cnt_d   = '0;
        end else if (run_en) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
            if (q_q == '0) begin
                q_d     = DEFAULT_SEED;
                start_d = DEFAULT_SEED;
                cnt_d   = '0;
            end else begin
`else
            begin
`endif
                q_d = q_step;
                if (q_step == start_q) begin
                    // Back at the start value: one full period completed.
                    pd_d  = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q     <= DEFAULT_SEED;
            start_q <= DEFAULT_SEED;
            cnt_q   <= '0;
            pd_q    <= 1'b0;
        end else begin
            q_q     <= q_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            pd_q    <= pd_d;
        end
    end

    // Outputs come straight from the registers; lockup is decoded from the registered state.
    always_comb begin
        q           = q_q;
        out_bit     = q_q[WIDTH-1];
        step_cnt    = cnt_q;
        period_done = pd_q;
        lockup      = (q_q == '0);
    end

endmodule
